// File: rtl/my_types_pkg.sv
// rtl/my_types_pkg.sv - shared types for the pipeline sequencer
package my_types_pkg;

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} seq_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_IDLE = '0;
  localparam pipe_ctrl_t CTRL_ADV  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                       idex_en: 1'b1, idex_flush: 1'b0, exmem_en: 1'b1,
                                       exmem_flush: 1'b0, memwb_en: 1'b1};

endpackage

// File: rtl/event_counter.sv
// rtl/event_counter.sv - wrapping event counter with async active-low reset
module event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - stall/flush sequencing, halt drain FSM and perf counters
module pipeline_sequencer
  import my_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_DataRead,
  input  logic [4:0]       ex_wsel,
  input  logic             mem_DataRead,
  input  logic             mem_DataWrite,
  input  logic             mem_ctrl_taken,
  input  logic             mem_Halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             imemREN,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] dwait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  seq_state_t state_q, state_d;
  logic       halt_q;
  pipe_ctrl_t ctrl;
  logic       imem_ren_raw;
  logic       memreq, adv, load_use;
  logic       stall_inc, dwait_inc, flush_inc;

  assign memreq   = mem_DataRead | mem_DataWrite;
  assign adv      = memreq ? dhit : ihit;
  assign load_use = ex_DataRead && (ex_wsel != 5'd0) &&
                    ((ex_wsel == id_rs) || (ex_wsel == id_rt));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DRAIN) begin
        halt_q <= 1'b1;
      end
    end
  end

  always_comb begin
    ctrl         = CTRL_IDLE;
    state_d      = state_q;
    imem_ren_raw = 1'b0;
    stall_inc    = 1'b0;
    dwait_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state_q)
      RUN, DWAIT: begin
        imem_ren_raw = 1'b1;
        dwait_inc    = (state_q == DWAIT);
        if (!adv) begin
          state_d = memreq ? DWAIT : RUN;
        end else begin
          ctrl    = CTRL_ADV;
          state_d = RUN;
          // A data-side advance consumed the cycle, so the fetch in IF is replayed.
          if (memreq) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.pc_en      = 1'b0;
          end
          if (mem_Halt) begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            ctrl.pc_en       = 1'b0;
            state_d          = DRAIN;
          end else if (mem_ctrl_taken) begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            ctrl.pc_en       = 1'b1;
            flush_inc        = 1'b1;
          end else if (load_use) begin
            ctrl.ifid_en    = 1'b0;
            ctrl.pc_en      = 1'b0;
            ctrl.idex_flush = 1'b1;
          end
        end
        stall_inc = !ctrl.pc_en;
      end
      DRAIN:   state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  assign pc_en       = nRST & ctrl.pc_en;
  assign ifid_en     = nRST & ctrl.ifid_en;
  assign idex_en     = nRST & ctrl.idex_en;
  assign exmem_en    = nRST & ctrl.exmem_en;
  assign memwb_en    = nRST & ctrl.memwb_en;
  assign ifid_flush  = nRST & ctrl.ifid_flush;
  assign idex_flush  = nRST & ctrl.idex_flush;
  assign exmem_flush = nRST & ctrl.exmem_flush;
  assign imemREN     = nRST & imem_ren_raw;
  assign halt        = halt_q;

  event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK(CLK), .nRST(nRST), .inc(stall_inc), .count(stall_cnt)
  );

  event_counter #(.CNT_W(CNT_W)) u_dwait_cnt (
    .CLK(CLK), .nRST(nRST), .inc(dwait_inc), .count(dwait_cnt)
  );

  event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK(CLK), .nRST(nRST), .inc(flush_inc), .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - directed table-driven bench for pipeline_sequencer
module tb_pipeline_sequencer;

  localparam int CNT_W = 32;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic nRST;
  logic ihit, dhit, ex_DataRead, mem_DataRead, mem_DataWrite, mem_ctrl_taken, mem_Halt;
  logic [4:0] id_rs, id_rt, ex_wsel;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, imemREN, halt;
  logic [CNT_W-1:0] stall_cnt, dwait_cnt, flush_cnt;

  pipeline_sequencer #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .ex_DataRead(ex_DataRead), .ex_wsel(ex_wsel),
    .mem_DataRead(mem_DataRead), .mem_DataWrite(mem_DataWrite),
    .mem_ctrl_taken(mem_ctrl_taken), .mem_Halt(mem_Halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .imemREN(imemREN), .halt(halt),
    .stall_cnt(stall_cnt), .dwait_cnt(dwait_cnt), .flush_cnt(flush_cnt)
  );

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en}
  logic [7:0] ctrl_w;
  assign ctrl_w = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en};

  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_ADV   = 8'b1101_0101;
  localparam logic [7:0] C_LU    = 8'b0001_1101;
  localparam logic [7:0] C_TAKEN = 8'b1111_1111;
  localparam logic [7:0] C_DHIT  = 8'b0111_0101;
  localparam logic [7:0] C_HALT  = 8'b0111_1111;

  typedef struct {
    logic       ihit, dhit;
    logic [4:0] rs, rt;
    logic       exr;
    logic [4:0] wsel;
    logic       mr, mw, tk;
    logic [7:0] exp_ctrl;
  } vec_t;

  vec_t vecs[10];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ihit = 0; dhit = 0; id_rs = 0; id_rt = 0; ex_DataRead = 0; ex_wsel = 0;
    mem_DataRead = 0; mem_DataWrite = 0; mem_ctrl_taken = 0; mem_Halt = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 0;
    @(negedge CLK);
    nRST = 1;
  endtask

  initial begin
    int exp_stall, exp_flush;

    vecs[0] = '{1, 0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, C_ADV};
    vecs[1] = '{0, 0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, C_IDLE};
    vecs[2] = '{1, 0, 5'd1, 5'd8, 1, 5'd8, 0, 0, 0, C_LU};
    vecs[3] = '{1, 0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, C_ADV};
    vecs[4] = '{1, 0, 5'd5, 5'd9, 1, 5'd5, 0, 0, 0, C_LU};
    vecs[5] = '{1, 0, 5'd5, 5'd9, 0, 5'd5, 0, 0, 0, C_ADV};
    vecs[6] = '{1, 0, 5'd7, 5'd2, 1, 5'd7, 0, 0, 1, C_TAKEN};
    vecs[7] = '{0, 1, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, C_DHIT};
    vecs[8] = '{1, 0, 5'd3, 5'd4, 1, 5'd8, 0, 0, 0, C_ADV};
    vecs[9] = '{1, 0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, C_ADV};

    // Reset state: outputs forced low even with ihit asserted.
    idle_inputs();
    nRST = 0;
    ihit = 1;
    #1;
    check("reset_ctrl", {24'd0, ctrl_w}, {24'd0, C_IDLE});
    check("reset_imemREN", {31'd0, imemREN}, 32'd0);
    check("reset_halt", {31'd0, halt}, 32'd0);
    check("reset_counters", stall_cnt | dwait_cnt | flush_cnt, 32'd0);
    @(negedge CLK);
    nRST = 1;

    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 10; i++) begin
      ihit = vecs[i].ihit; dhit = vecs[i].dhit;
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      ex_DataRead = vecs[i].exr; ex_wsel = vecs[i].wsel;
      mem_DataRead = vecs[i].mr; mem_DataWrite = vecs[i].mw;
      mem_ctrl_taken = vecs[i].tk; mem_Halt = 0;
      #1;
      check($sformatf("vec%0d_ctrl", i), {24'd0, ctrl_w}, {24'd0, vecs[i].exp_ctrl});
      check($sformatf("vec%0d_imemREN", i), {31'd0, imemREN}, 32'd1);
      if (!vecs[i].exp_ctrl[7]) exp_stall++;
      if (vecs[i].tk) exp_flush++;
      @(negedge CLK);
    end
    check("table_stall_cnt", stall_cnt, exp_stall);
    check("table_flush_cnt", flush_cnt, exp_flush);
    check("table_dwait_cnt", dwait_cnt, 32'd0);

    // Load waits three cycles for dhit.
    do_reset();
    mem_DataRead = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("dwait%0d_ctrl", i), {24'd0, ctrl_w}, {24'd0, C_IDLE});
      check($sformatf("dwait%0d_imemREN", i), {31'd0, imemREN}, 32'd1);
      @(negedge CLK);
    end
    dhit = 1;
    #1;
    check("dhit_ctrl", {24'd0, ctrl_w}, {24'd0, C_DHIT});
    @(negedge CLK);
    idle_inputs();
    #1;
    check("dwait_dwait_cnt", dwait_cnt, 32'd3);
    check("dwait_stall_cnt", stall_cnt, 32'd4);
    check("dwait_back_to_run", {24'd0, ctrl_w}, {24'd0, C_IDLE});

    // Asynchronous reset while sitting in DWAIT with counters nonzero.
    mem_DataWrite = 1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("pre_rst_dwait_cnt", dwait_cnt, 32'd4);
    nRST = 0;
    #1;
    check("async_rst_ctrl", {24'd0, ctrl_w}, {24'd0, C_IDLE});
    check("async_rst_imemREN", {31'd0, imemREN}, 32'd0);
    check("async_rst_counters", stall_cnt | dwait_cnt | flush_cnt, 32'd0);
    @(negedge CLK);
    nRST = 1;
    idle_inputs();
    ihit = 1;
    #1;
    check("post_rst_run_ctrl", {24'd0, ctrl_w}, {24'd0, C_ADV});
    check("post_rst_halt", {31'd0, halt}, 32'd0);

    // Halt retirement and drain.
    do_reset();
    ihit = 1;
    mem_Halt = 1;
    #1;
    check("halt_ctrl", {24'd0, ctrl_w}, {24'd0, C_HALT});
    @(negedge CLK);
    mem_Halt = 0;
    #1;
    check("drain_ctrl", {24'd0, ctrl_w}, {24'd0, C_IDLE});
    check("drain_imemREN", {31'd0, imemREN}, 32'd0);
    check("drain_halt", {31'd0, halt}, 32'd0);
    @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      ihit = i[0];
      dhit = ~i[0];
      mem_DataRead = i[1];
      mem_ctrl_taken = i[2];
      #1;
      check($sformatf("halted%0d_ctrl", i), {24'd0, ctrl_w}, {24'd0, C_IDLE});
      check($sformatf("halted%0d_imemREN", i), {31'd0, imemREN}, 32'd0);
      check($sformatf("halted%0d_halt", i), {31'd0, halt}, 32'd1);
      @(negedge CLK);
    end
    check("halted_stall_cnt", stall_cnt, 32'd1);
    check("halted_dwait_cnt", dwait_cnt, 32'd0);
    check("halted_flush_cnt", flush_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
